// File: rtl/conv_feeder.sv
// conv_feeder: job sequencer feeding filter words and pixels
// into the convolver array line buffers, with MAC window strobes.
module conv_feeder #(
  parameter int ADDR_FIFO  = 8,
  parameter int ROW_W      = 10,
  parameter int WID_LINE   = 16,
  parameter int WID_FILTER = 16,
  parameter int K          = 3,
  parameter int DRAIN_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_FIFO-1:0]  cfg_row_length,
  input  logic [ROW_W-1:0]      cfg_num_rows,
  input  logic                  filt_valid,
  output logic                  filt_ready,
  input  logic [WID_FILTER-1:0] filt_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [WID_LINE-1:0]   pix_data,
  output logic                  line_buffer_reset,
  output logic [ADDR_FIFO-1:0]  row_length,
  output logic                  shifting_filter,
  output logic [WID_FILTER-1:0] input_filter,
  output logic                  shifting_line,
  output logic [WID_LINE-1:0]   input_line,
  output logic                  mac_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int FW = $clog2(K*K+1);
  localparam int DW = $clog2(DRAIN_CYC+1);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD_FILT, STREAM, DRAIN
  } state_t;

  state_t state, next_state;

  logic [ADDR_FIFO-1:0] col;
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     num_rows;
  logic [FW-1:0]        filt_cnt;
  logic [DW-1:0]        drain_cnt;

  logic cfg_bad, filt_hs, pix_hs;
  logic last_filt, last_col, last_pix, drain_end;

  assign filt_ready        = (state == LOAD_FILT);
  assign pix_ready         = (state == STREAM);
  assign line_buffer_reset = (state == CLR);
  assign busy              = (state != IDLE);

  assign cfg_bad   = (cfg_row_length < ADDR_FIFO'(K)) ||
                     (cfg_num_rows < ROW_W'(K));
  assign filt_hs   = filt_ready & filt_valid;
  assign pix_hs    = pix_ready & pix_valid;
  assign last_filt = (filt_cnt == FW'(K*K-1));
  assign last_col  = (col == row_length - ADDR_FIFO'(1));
  assign last_pix  = last_col && (row == num_rows - ROW_W'(1));
  assign drain_end = (drain_cnt == DW'(DRAIN_CYC-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (start && !cfg_bad) next_state = CLR;
      CLR:       next_state = LOAD_FILT;
      LOAD_FILT: if (filt_hs && last_filt) next_state = STREAM;
      STREAM:    if (pix_hs && last_pix) next_state = DRAIN;
      DRAIN:     if (drain_end) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_length      <= '0;
      num_rows        <= '0;
      col             <= '0;
      row             <= '0;
      filt_cnt        <= '0;
      drain_cnt       <= '0;
      shifting_filter <= 1'b0;
      input_filter    <= '0;
      shifting_line   <= 1'b0;
      input_line      <= '0;
      mac_enable      <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      shifting_filter <= 1'b0;
      shifting_line   <= 1'b0;
      mac_enable      <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && cfg_bad) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (start) begin
            row_length <= cfg_row_length;
            num_rows   <= cfg_num_rows;
          end
        end
        CLR: begin
          col       <= '0;
          row       <= '0;
          filt_cnt  <= '0;
          drain_cnt <= '0;
        end
        LOAD_FILT: begin
          if (filt_hs) begin
            input_filter    <= filt_data;
            shifting_filter <= 1'b1;
            filt_cnt        <= filt_cnt + FW'(1);
          end
        end
        STREAM: begin
          if (pix_hs) begin
            input_line    <= pix_data;
            shifting_line <= 1'b1;
            // window is complete only once K-1 rows and columns precede it
            mac_enable    <= (row >= ROW_W'(K-1)) &&
                             (col >= ADDR_FIFO'(K-1));
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + ADDR_FIFO'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_end) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: randomized jobs checked against a queue-based
// model of the expected filter/pixel streams and window strobes.
module tb_conv_feeder;

  localparam int K  = 3;
  localparam int DC = 4;

  logic        clk = 0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_row_length;
  logic [9:0]  cfg_num_rows;
  logic        filt_valid, filt_ready;
  logic [15:0] filt_data;
  logic        pix_valid, pix_ready;
  logic [15:0] pix_data;
  logic        line_buffer_reset;
  logic [7:0]  row_length;
  logic        shifting_filter;
  logic [15:0] input_filter;
  logic        shifting_line;
  logic [15:0] input_line;
  logic        mac_enable, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  conv_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row_length(cfg_row_length), .cfg_num_rows(cfg_num_rows),
    .filt_valid(filt_valid), .filt_ready(filt_ready),
    .filt_data(filt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .line_buffer_reset(line_buffer_reset), .row_length(row_length),
    .shifting_filter(shifting_filter), .input_filter(input_filter),
    .shifting_line(shifting_line), .input_line(input_line),
    .mac_enable(mac_enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {filt_ready, pix_ready, line_buffer_reset, row_length,
            shifting_filter, input_filter, shifting_line, input_line,
            mac_enable, busy, done, err};
  endfunction

  function automatic bit want_valid(int mode, int t);
    if (mode == 0) return 1'b1;
    if (mode == 1) return t[0];
    return ($urandom_range(0, 3) != 0);
  endfunction

  // mode: 0 continuous, 1 alternate, 2 random valids
  // abort_at: assert rst after that many pixel strobes (-1: never)
  task automatic run_job(int L, int R, int mode, bit poke, int abort_at);
    logic [15:0] fq[$];
    logic [15:0] pq[$];
    bit          mq[$];
    int fi = 0, pi = 0, nf = 0, np = 0, nm = 0, lbr = 0;
    int t = 0, last_hs = -1, done_t = -1, n_done = 0;
    bit seen_fr = 0, poked_f = 0, poked_p = 0;
    for (int i = 0; i < K*K; i++) fq.push_back(16'($urandom));
    for (int i = 0; i < L*R; i++) begin
      pq.push_back(16'($urandom));
      mq.push_back(((i / L) >= K-1) && ((i % L) >= K-1));
    end
    @(negedge clk);
    cfg_row_length = 8'(L);
    cfg_num_rows   = 10'(R);
    start = 1;
    while (t < 3000) begin
      @(negedge clk);
      t++;
      start = 0;
      if (line_buffer_reset) begin
        lbr++;
        if (lbr == 1) begin
          check("lbr_latency", 64'(t), 64'd1);
          check("row_length", 64'(row_length), 64'(L));
          check("busy_job", 64'(busy), 64'd1);
        end
      end
      if (filt_ready && !seen_fr) begin
        seen_fr = 1;
        check("filt_ready_latency", 64'(t), 64'd2);
      end
      if (shifting_filter) begin
        if (nf < K*K) check("filt_word", 64'(input_filter), 64'(fq[nf]));
        else check("extra_filt", 64'd1, 64'd0);
        nf++;
      end
      if (shifting_line) begin
        if (np < L*R) begin
          check("pix_word", 64'(input_line), 64'(pq[np]));
          check("mac_flag", 64'(mac_enable), 64'(mq[np]));
        end else check("extra_pix", 64'd1, 64'd0);
        np++;
      end
      if (mac_enable) begin
        nm++;
        if (!shifting_line) check("mac_in_gap", 64'd1, 64'd0);
      end
      if (done) begin
        n_done++;
        if (done_t < 0) begin
          done_t = t;
          check("err_on_good_job", 64'(err), 64'd0);
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
      if (abort_at >= 0 && np == abort_at) begin
        rst = 1;
        filt_valid = 0;
        pix_valid  = 0;
        @(negedge clk);
        rst = 0;
        check("abort_outs_zero", all_outs(), 64'd0);
        @(negedge clk);
        check("abort_no_done", 64'(done | busy), 64'd0);
        return;
      end
      if (done_t >= 0 && (!poke || t >= done_t + 3)) break;
      if (poke && filt_ready && nf == 2 && !poked_f) begin
        start = 1;
        poked_f = 1;
      end
      if (poke && pix_ready && np == 3 && !poked_p) begin
        start = 1;
        poked_p = 1;
      end
      filt_valid = (fi < K*K) && want_valid(mode, t);
      filt_data  = (fi < K*K) ? fq[fi] : 16'hdead;
      if (filt_valid && filt_ready) fi++;
      pix_valid = (pi < L*R) && want_valid(mode, t);
      pix_data  = (pi < L*R) ? pq[pi] : 16'hbeef;
      if (pix_valid && pix_ready) begin
        pi++;
        if (pi == L*R) last_hs = t;
      end
    end
    filt_valid = 0;
    pix_valid  = 0;
    if (done_t < 0) check("done_timeout", 64'd0, 64'd1);
    check("lbr_count", 64'(lbr), 64'd1);
    check("filt_count", 64'(nf), 64'(K*K));
    check("pix_count", 64'(np), 64'(L*R));
    check("mac_count", 64'(nm), 64'((R-K+1)*(L-K+1)));
    check("done_latency", 64'(done_t - last_hs), 64'(DC+1));
    check("done_count", 64'(n_done), 64'd1);
  endtask

  task automatic bad_cfg(int L, int R);
    @(negedge clk);
    cfg_row_length = 8'(L);
    cfg_num_rows   = 10'(R);
    start = 1;
    @(negedge clk);
    start = 0;
    check("bad_done_err", 64'({done, err, busy}), 64'b110);
    check("bad_no_strobe", 64'({line_buffer_reset, shifting_filter,
          shifting_line, mac_enable, filt_ready}), 64'd0);
    @(negedge clk);
    check("bad_pulse_end", 64'({done, err, busy}), 64'd0);
  endtask

  initial begin
    rst = 1;
    start = 0;
    cfg_row_length = 0;
    cfg_num_rows = 0;
    filt_valid = 0;
    filt_data = 0;
    pix_valid = 0;
    pix_data = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 0;
    run_job(4, 4, 0, 0, -1);
    run_job(4, 4, 1, 0, -1);
    bad_cfg(2, 5);
    bad_cfg(5, 2);
    run_job(4, 4, 0, 1, -1);
    run_job(5, 5, 0, 0, 7);
    run_job(3, 3, 0, 0, -1);
    run_job(4, 3, 0, 0, -1);
    run_job(4, 3, 0, 0, -1);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(3, 7), $urandom_range(3, 6), 2, j[0], -1);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
